// File: rtl/mem_region_router_if.sv
// mem_region_router_if: CPU load/store port and bank-side bus.
// slave = router view, master = CPU/bank environment view.
interface mem_region_router_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_BANKS      = 2,
  parameter int BANK_SIZE_LOG2 = 16
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic                        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;
  logic [NUM_BANKS-1:0]        bank_req_valid;
  logic [NUM_BANKS-1:0]        bank_req_ready;
  logic                        bank_we;
  logic [BANK_SIZE_LOG2-1:0]   bank_addr;
  logic [DATA_W-1:0]           bank_wdata;
  logic [NUM_BANKS-1:0]        bank_rsp_valid;
  logic [NUM_BANKS*DATA_W-1:0] bank_rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bank_req_valid, bank_we, bank_addr, bank_wdata,
    input  bank_req_ready, bank_rsp_valid, bank_rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bank_req_valid, bank_we, bank_addr, bank_wdata,
    output bank_req_ready, bank_rsp_valid, bank_rsp_rdata
  );
endinterface

// File: rtl/mem_region_router.sv
// mem_region_router: routes one CPU load/store at a time to a
// data-memory bank, with out-of-range and timeout error responses.
module mem_region_router #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_BANKS      = 2,
  parameter int BANK_SIZE_LOG2 = 16,
  parameter int TIMEOUT        = 255
) (
  input logic               clk,
  input logic               rst,
  mem_region_router_if.slave bus
);

  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int IW    = (IDX_W > 0) ? IDX_W : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  // One extra bit so the region limit cannot wrap.
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(NUM_BANKS) << BANK_SIZE_LOG2;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, ERR
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     req_idx;
  logic              in_range;
  logic              sel_ready;
  logic              sel_rsp;
  logic [DATA_W-1:0] sel_rdata;
  logic [DATA_W-1:0] rdata_arr [NUM_BANKS];

  generate
    if (IDX_W > 0) begin : g_idx
      assign req_idx = bus.req_addr[BANK_SIZE_LOG2 +: IW];
    end else begin : g_noidx
      assign req_idx = '0;
    end
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_rd
      assign rdata_arr[g] = bus.bank_rsp_rdata[g*DATA_W +: DATA_W];
    end
  endgenerate

  assign in_range  = {1'b0, bus.req_addr} < LIMIT;
  assign sel_ready = bus.bank_req_ready[idx_q];
  assign sel_rsp   = bus.bank_rsp_valid[idx_q];
  assign sel_rdata = rdata_arr[idx_q];

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      idx_q              <= '0;
      bus.req_ready      <= 1'b1;
      bus.rsp_valid      <= 1'b0;
      bus.rsp_err        <= 1'b0;
      bus.rsp_rdata      <= '0;
      bus.bank_req_valid <= '0;
      bus.bank_we        <= 1'b0;
      bus.bank_addr      <= '0;
      bus.bank_wdata     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            idx_q          <= req_idx;
            bus.bank_we    <= bus.req_we;
            bus.bank_addr  <= bus.req_addr[BANK_SIZE_LOG2-1:0];
            bus.bank_wdata <= bus.req_wdata;
            bus.req_ready  <= 1'b0;
            cnt            <= '0;
            if (in_range) begin
              state              <= ISSUE;
              bus.bank_req_valid <= NUM_BANKS'(1) << req_idx;
            end else begin
              state         <= ERR;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (sel_ready) begin
            state              <= WAIT;
            bus.bank_req_valid <= '0;
            cnt                <= cnt + 1'b1;
          end else if (cnt == CNT_MAX) begin
            state              <= ERR;
            bus.bank_req_valid <= '0;
            bus.rsp_valid      <= 1'b1;
            bus.rsp_err        <= 1'b1;
            bus.rsp_rdata      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (sel_rsp) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= bus.bank_we ? '0 : sel_rdata;
          end else if (cnt == CNT_MAX) begin
            state         <= ERR;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP, ERR: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
        end
        default: begin
          state              <= IDLE;
          bus.req_ready      <= 1'b1;
          bus.rsp_valid      <= 1'b0;
          bus.rsp_err        <= 1'b0;
          bus.bank_req_valid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_region_router.sv
// tb_mem_region_router: directed checks of decode, handshake,
// out-of-range, timeout, foreign-bank pulses and mid-transaction reset.
module tb_mem_region_router;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NB      = 2;
  localparam int BSL2    = 16;
  localparam int TMO     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_region_router_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .NUM_BANKS(NB), .BANK_SIZE_LOG2(BSL2)
  ) bus ();

  mem_region_router #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BANKS(NB),
    .BANK_SIZE_LOG2(BSL2), .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_rspv"},  64'(bus.rsp_valid), 64'd0);
    chk({tag, "_err"},   64'(bus.rsp_err), 64'd0);
    chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    chk({tag, "_breqv"}, 64'(bus.bank_req_valid), 64'd0);
    chk({tag, "_we"},    64'(bus.bank_we), 64'd0);
    chk({tag, "_addr"},  64'(bus.bank_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(bus.bank_wdata), 64'd0);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    step();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_we         = 1'b0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.bank_req_ready = '0;
    bus.bank_rsp_valid = '0;
    bus.bank_rsp_rdata = '0;

    step();
    step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();
    chk("idle_ready", 64'(bus.req_ready), 64'd1);

    // 1: read bank 0, ready at once, data next cycle
    bus.bank_req_ready = 2'b01;
    issue(1'b0, 32'h0000_0010, 32'h0);
    chk("t1_breqv", 64'(bus.bank_req_valid), 64'h1);
    chk("t1_addr",  64'(bus.bank_addr), 64'h10);
    chk("t1_we",    64'(bus.bank_we), 64'h0);
    chk("t1_busy",  64'(bus.req_ready), 64'h0);
    step();
    chk("t1_breqv_drop", 64'(bus.bank_req_valid), 64'h0);
    bus.bank_rsp_valid = 2'b01;
    bus.bank_rsp_rdata = {32'h0, 32'hDEAD_BEEF};
    step();
    bus.bank_rsp_valid = '0;
    chk("t1_rspv",  64'(bus.rsp_valid), 64'h1);
    chk("t1_rdata", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);
    chk("t1_err",   64'(bus.rsp_err), 64'h0);
    step();
    chk("t1_rsp_1cyc", 64'(bus.rsp_valid), 64'h0);
    chk("t1_ready",    64'(bus.req_ready), 64'h1);

    // 2: write bank 1, ready low for 3 cycles
    bus.bank_req_ready = 2'b00;
    issue(1'b1, 32'h0001_0004, 32'h1234_5678);
    chk("t2_addr",  64'(bus.bank_addr), 64'h4);
    chk("t2_we",    64'(bus.bank_we), 64'h1);
    chk("t2_wdata", 64'(bus.bank_wdata), 64'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_breqv_c%0d", i + 1),
          64'(bus.bank_req_valid), 64'h2);
      if (i == 3) bus.bank_req_ready = 2'b10;
      step();
    end
    bus.bank_req_ready = 2'b00;
    chk("t2_breqv_drop", 64'(bus.bank_req_valid), 64'h0);
    bus.bank_rsp_valid = 2'b10;
    bus.bank_rsp_rdata = {32'hAAAA_5555, 32'h0};
    step();
    bus.bank_rsp_valid = '0;
    chk("t2_rspv",  64'(bus.rsp_valid), 64'h1);
    chk("t2_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("t2_err",   64'(bus.rsp_err), 64'h0);
    step();

    // 3: out of range
    issue(1'b0, 32'h0002_0000, 32'h0);
    chk("t3_breqv", 64'(bus.bank_req_valid), 64'h0);
    chk("t3_rspv",  64'(bus.rsp_valid), 64'h1);
    chk("t3_err",   64'(bus.rsp_err), 64'h1);
    chk("t3_rdata", 64'(bus.rsp_rdata), 64'h0);
    step();
    chk("t3_ready", 64'(bus.req_ready), 64'h1);
    chk("t3_rspv0", 64'(bus.rsp_valid), 64'h0);

    // 4: bank 0 accepts but never responds
    bus.bank_req_ready = 2'b01;
    issue(1'b0, 32'h0000_0020, 32'h0);
    for (int c = 1; c <= TMO; c++) begin
      chk($sformatf("t4_quiet_c%0d", c), 64'(bus.rsp_valid), 64'h0);
      step();
    end
    chk("t4_rspv",  64'(bus.rsp_valid), 64'h1);
    chk("t4_err",   64'(bus.rsp_err), 64'h1);
    chk("t4_rdata", 64'(bus.rsp_rdata), 64'h0);
    chk("t4_breqv", 64'(bus.bank_req_valid), 64'h0);
    step();
    chk("t4_ready", 64'(bus.req_ready), 64'h1);
    bus.bank_rsp_valid = 2'b01;
    bus.bank_rsp_rdata = {32'h0, 32'h5A5A_5A5A};
    step();
    bus.bank_rsp_valid = '0;
    chk("t4_late_c11", 64'(bus.rsp_valid), 64'h0);
    step();
    chk("t4_late_c12", 64'(bus.rsp_valid), 64'h0);
    chk("t4_ready2",   64'(bus.req_ready), 64'h1);

    // 5: read bank 1, bank 0 pulses in WAIT
    bus.bank_req_ready = 2'b10;
    issue(1'b0, 32'h0001_0100, 32'h0);
    chk("t5_breqv", 64'(bus.bank_req_valid), 64'h2);
    chk("t5_addr",  64'(bus.bank_addr), 64'h100);
    step();
    bus.bank_req_ready = 2'b00;
    bus.bank_rsp_valid = 2'b01;
    bus.bank_rsp_rdata = {32'h2222_2222, 32'h1111_1111};
    step();
    chk("t5_ignore", 64'(bus.rsp_valid), 64'h0);
    bus.bank_rsp_valid = 2'b10;
    bus.bank_rsp_rdata = {32'hCAFE_F00D, 32'h1111_1111};
    step();
    bus.bank_rsp_valid = '0;
    chk("t5_rspv",  64'(bus.rsp_valid), 64'h1);
    chk("t5_rdata", 64'(bus.rsp_rdata), 64'hCAFE_F00D);
    chk("t5_err",   64'(bus.rsp_err), 64'h0);
    step();

    // 6: reset while in WAIT
    bus.bank_req_ready = 2'b01;
    issue(1'b1, 32'h0000_0040, 32'h7777_0000);
    step();
    bus.bank_req_ready = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("t6");
    bus.bank_rsp_valid = 2'b01;
    bus.bank_rsp_rdata = {32'h0, 32'h0BAD_0BAD};
    step();
    bus.bank_rsp_valid = '0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t6_norsp_%0d", c), 64'(bus.rsp_valid), 64'h0);
      step();
    end

    // back-to-back sanity after reset
    bus.bank_req_ready = 2'b01;
    issue(1'b0, 32'h0000_FFFC, 32'h0);
    chk("t7_addr", 64'(bus.bank_addr), 64'hFFFC);
    step();
    bus.bank_rsp_valid = 2'b01;
    bus.bank_rsp_rdata = {32'h0, 32'h0000_0042};
    step();
    bus.bank_rsp_valid = '0;
    chk("t7_rdata", 64'(bus.rsp_rdata), 64'h42);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
